// File: rtl/vc_fifo_pkg.sv
// Purpose: shared types, defaults and helpers for the multi-VC flit buffer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package vc_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 37;
  localparam int NUM_VC_DEF     = 4;

  typedef logic [DATA_WIDTH_DEF-1:0]     flit_t;
  typedef logic [$clog2(NUM_VC_DEF)-1:0] vc_id_t;

  // LSB of VC 'vc' inside the packed per-VC occupancy bus.
  function automatic int count_lsb(input int vc, input int cnt_w);
    return vc * cnt_w;
  endfunction

endpackage

// File: rtl/vc_fifo_chan.sv
// Purpose: single-VC storage (memory, pointers, occupancy, flags).
// Latency: head is a combinational view of the oldest entry; push/pop take effect next edge.
// Backpressure: none internally; the parent only pushes when not full (or popping) and pops when not empty.
//
// Ports: clk, rst_n (sync, active-low); push/wr_data store a flit; pop drops the head;
//        head = oldest flit; count = occupancy 0..DEPTH; empty/full/almost_full from count.
module vc_fifo_chan
  import vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] head,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  // Pointers wrap naturally at DEPTH; count carries the extra bit so all DEPTH slots are usable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not cleared on reset.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= wr_data;
  end

  assign head        = mem[rd_ptr];
  assign empty       = (count == '0);
  assign full        = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign almost_full = (int'(count) >= AF_THRESH);

endmodule

// File: rtl/vc_fifo.sv
// Purpose: NUM_VC independent flit FIFOs behind one shared write port and one shared read port.
// Latency: 1 cycle read (rd_data/rd_valid registered); 0 cycles when VC_FIFO_FWFT_EN is defined.
// Backpressure: upstream watches full/almost_full/count; dropped writes/reads raise sticky errors.
//
// Ports: clk, rst_n (sync, active-low); wr_en/wr_vc/wr_data write request; rd_en/rd_vc read request;
//        rd_data/rd_valid popped flit; empty/full/almost_full per-VC flags; count packed per-VC
//        occupancy (ADDR_WIDTH+1 bits per VC); overflow_err/underflow_err sticky until reset.
// Build option: define VC_FIFO_FWFT_EN for first-word-fall-through reads.
module vc_fifo
  import vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_VC     = NUM_VC_DEF,
  parameter int VC_W       = $clog2(NUM_VC),
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [VC_W-1:0]                wr_vc,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rd_en,
  input  logic [VC_W-1:0]                rd_vc,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  output logic [NUM_VC-1:0]              empty,
  output logic [NUM_VC-1:0]              full,
  output logic [NUM_VC-1:0]              almost_full,
  output logic [NUM_VC*(ADDR_WIDTH+1)-1:0] count,
  output logic                           overflow_err,
  output logic                           underflow_err
);

  localparam int CW = ADDR_WIDTH + 1;

  logic                  wr_ok, rd_ok;
  logic                  wr_acc, rd_acc;
  logic [NUM_VC-1:0]     push, pop;
  logic [DATA_WIDTH-1:0] heads [NUM_VC];
  logic [DATA_WIDTH-1:0] rd_head;

  // Indices beyond NUM_VC are only possible when NUM_VC is not a power of two.
  assign wr_ok = (int'(wr_vc) < NUM_VC);
  assign rd_ok = (int'(rd_vc) < NUM_VC);

  assign rd_acc = rd_en && rd_ok && !empty[rd_vc];
  // A full VC still accepts a write when the same cycle pops it (full implies the pop is accepted).
  assign wr_acc = wr_en && wr_ok && (!full[wr_vc] || (rd_acc && (rd_vc == wr_vc)));

  assign rd_head = rd_ok ? heads[rd_vc] : '0;

  for (genvar k = 0; k < NUM_VC; k++) begin : g_chan
    assign push[k] = wr_acc && (wr_vc == VC_W'(k));
    assign pop[k]  = rd_acc && (rd_vc == VC_W'(k));

    vc_fifo_chan #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .AF_THRESH  (AF_THRESH)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push[k]),
      .pop         (pop[k]),
      .wr_data     (wr_data),
      .head        (heads[k]),
      .count       (count[count_lsb(k, CW) +: CW]),
      .empty       (empty[k]),
      .full        (full[k]),
      .almost_full (almost_full[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) overflow_err  <= 1'b1;
      if (rd_en && !rd_acc) underflow_err <= 1'b1;
    end
  end

`ifdef VC_FIFO_FWFT_EN
  assign rd_data  = rd_head;
  assign rd_valid = rd_ok && !empty[rd_vc];
`else
  // rd_data keeps the last popped flit until the next accepted read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= rd_head;
    end
  end
`endif

endmodule

// File: tb/tb_vc_fifo.sv
module tb_vc_fifo;
  import vc_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  vc_id_t      wr_vc;
  flit_t       wr_data;
  logic        rd_en;
  vc_id_t      rd_vc;
  flit_t       rd_data;
  logic        rd_valid;
  logic [3:0]  empty, full, almost_full;
  logic [15:0] count;
  logic        overflow_err, underflow_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vc_fifo dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_vc         (wr_vc),
    .wr_data       (wr_data),
    .rd_en         (rd_en),
    .rd_vc         (rd_vc),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .empty         (empty),
    .full          (full),
    .almost_full   (almost_full),
    .count         (count),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  typedef struct {
    bit         rst;
    bit         we;
    bit [1:0]   wvc;
    flit_t      wd;
    bit         re;
    bit [1:0]   rvc;
    bit [1:0]   cvc;   // VC whose count/full/almost_full are checked
    int         cnt;
    bit         vld;
    bit         cd;    // check rd_data
    flit_t      d;
    bit [3:0]   emp;
    bit         ovf;
    bit         unf;
  } vec_t;

  vec_t vq[$];

  function automatic void add(bit rst, bit we, bit [1:0] wvc, flit_t wd, bit re, bit [1:0] rvc,
                              bit [1:0] cvc, int cnt, bit vld, bit cd, flit_t d,
                              bit [3:0] emp, bit ovf, bit unf);
    vec_t v;
    v.rst = rst; v.we = we; v.wvc = wvc; v.wd = wd; v.re = re; v.rvc = rvc;
    v.cvc = cvc; v.cnt = cnt; v.vld = vld; v.cd = cd; v.d = d;
    v.emp = emp; v.ovf = ovf; v.unf = unf;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_vc = '0; wr_data = '0;
    rd_en = 1'b0; rd_vc = '0;
  endtask

  initial begin
    vec_t v;
    logic [3:0] c;
    flit_t fw;

    // VC2: fill to full, overflow, drain in order
    for (int i = 1; i <= 8; i++) add(0, 1, 2, flit_t'(i), 0, 0, 2, i, 0, 0, '0, 4'b1011, 0, 0);
    add(0, 1, 2, flit_t'(9), 0, 0, 2, 8, 0, 0, '0, 4'b1011, 1, 0);
    for (int k = 1; k <= 8; k++)
      add(0, 0, 0, '0, 1, 2, 2, 8-k, 1, 1, flit_t'(k), (k == 8) ? 4'b1111 : 4'b1011, 1, 0);
    add(1, 0, 0, '0, 0, 0, 2, 0, 0, 1, '0, 4'b1111, 0, 0);
    // VC1: fill, pass-through write+read while full, drain
    for (int i = 1; i <= 8; i++) add(0, 1, 1, flit_t'(8'h10 + i), 0, 0, 1, i, 0, 0, '0, 4'b1101, 0, 0);
    add(0, 1, 1, flit_t'(8'hAA), 1, 1, 1, 8, 1, 1, flit_t'(8'h11), 4'b1101, 0, 0);
    for (int k = 1; k <= 8; k++)
      add(0, 0, 0, '0, 1, 1, 1, 8-k, 1, 1, (k < 8) ? flit_t'(8'h11 + k) : flit_t'(8'hAA),
          (k == 8) ? 4'b1111 : 4'b1101, 0, 0);
    // VC0: read while empty with same-cycle write
    add(0, 1, 0, flit_t'(8'h55), 1, 0, 0, 1, 0, 0, '0, 4'b1110, 0, 1);
    add(0, 0, 0, '0, 1, 0, 0, 0, 1, 1, flit_t'(8'h55), 4'b1111, 0, 1);
    // VC3 across pointer wrap (20 flits), VC0 writes interleaved with VC3 reads
    for (int i = 0; i < 6; i++) add(0, 1, 3, flit_t'(8'h40 + i), 0, 0, 3, i+1, 0, 0, '0, 4'b0111, 0, 1);
    for (int j = 0; j < 14; j++)
      add(0, 1, 3, flit_t'(8'h46 + j), 1, 3, 3, 6, 1, 1, flit_t'(8'h40 + j), 4'b0111, 0, 1);
    for (int m = 0; m < 6; m++)
      add(0, 1, 0, flit_t'(8'h60 + m), 1, 3, 3, 5-m, 1, 1, flit_t'(8'h4E + m),
          (m == 5) ? 4'b1110 : 4'b0110, 0, 1);
    for (int m = 0; m < 6; m++)
      add(0, 0, 0, '0, 1, 0, 0, 5-m, 1, 1, flit_t'(8'h60 + m), (m == 5) ? 4'b1111 : 4'b1110, 0, 1);
    // Reset mid-operation with VC0 holding 5 wide flits and a read just accepted
    add(1, 0, 0, '0, 0, 0, 0, 0, 0, 1, '0, 4'b1111, 0, 0);
    add(0, 0, 0, '0, 1, 2, 2, 0, 0, 0, '0, 4'b1111, 0, 1);
    for (int i = 1; i <= 5; i++)
      add(0, 1, 0, flit_t'(37'h1A_5A5A_5A00) + flit_t'(i), 0, 0, 0, i, 0, 0, '0, 4'b1110, 0, 1);
    add(0, 1, 0, flit_t'(37'h1A_5A5A_5A06), 1, 0, 0, 5, 1, 1, flit_t'(37'h1A_5A5A_5A01), 4'b1110, 0, 1);
    add(1, 1, 0, flit_t'(8'h77), 1, 0, 0, 0, 0, 1, '0, 4'b1111, 0, 0);
    add(0, 0, 0, '0, 1, 0, 0, 0, 0, 0, '0, 4'b1111, 0, 1);

    // Hand-written power-on reset and reset-state checks
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset empty", 64'(empty), 64'hF);
    chk("reset full", 64'(full), 64'h0);
    chk("reset almost_full", 64'(almost_full), 64'h0);
    chk("reset count", 64'(count), 64'h0);
    chk("reset rd_valid", 64'(rd_valid), 64'h0);
    chk("reset rd_data", 64'(rd_data), 64'h0);
    chk("reset overflow_err", 64'(overflow_err), 64'h0);
    chk("reset underflow_err", 64'(underflow_err), 64'h0);

    // Table-driven vectors: drive on negedge, check 1 after the following posedge
    for (int n = 0; n < vq.size(); n++) begin
      v = vq[n];
      @(negedge clk);
      rst_n   = !v.rst;
      wr_en   = v.we;  wr_vc = v.wvc; wr_data = v.wd;
      rd_en   = v.re;  rd_vc = v.rvc;
      @(posedge clk);
      #1;
      c = count[v.cvc*4 +: 4];
      chk($sformatf("v%0d rd_valid", n), 64'(rd_valid), 64'(v.vld));
      if (v.cd) chk($sformatf("v%0d rd_data", n), 64'(rd_data), 64'(v.d));
      chk($sformatf("v%0d count[%0d]", n, v.cvc), 64'(c), 64'(v.cnt));
      chk($sformatf("v%0d full[%0d]", n, v.cvc), 64'(full[v.cvc]), 64'(v.cnt == 8));
      chk($sformatf("v%0d almost_full[%0d]", n, v.cvc), 64'(almost_full[v.cvc]), 64'(v.cnt >= 6));
      chk($sformatf("v%0d empty", n), 64'(empty), 64'(v.emp));
      chk($sformatf("v%0d overflow_err", n), 64'(overflow_err), 64'(v.ovf));
      chk($sformatf("v%0d underflow_err", n), 64'(underflow_err), 64'(v.unf));
    end

    // Hand-written: rd_data holds its last value across idle cycles after a read
    @(negedge clk);
    rst_n = 1'b1;
    fw = flit_t'(37'h0F_1234_5678);
    wr_en = 1'b1; wr_vc = 2'd3; wr_data = fw; rd_en = 1'b0;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; rd_vc = 2'd3;
    @(negedge clk);
    idle();
    chk("hold first rd_valid", 64'(rd_valid), 64'h1);
    chk("hold first rd_data", 64'(rd_data), 64'(fw));
    repeat (3) @(negedge clk);
    chk("hold idle rd_valid", 64'(rd_valid), 64'h0);
    chk("hold idle rd_data", 64'(rd_data), 64'(fw));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_fifo.md
Name: vc_fifo

Overview:
Multi-channel synchronous flit buffer for a switch input port. It holds NUM_VC independent FIFOs (virtual channels) behind one shared write port and one shared read port, each FIFO selected by a VC index. It exposes per-VC empty, full, almost-full and occupancy for the downstream arbiter and upstream credit logic. It also reports sticky overflow and underflow errors.

Parameters:
DATA_WIDTH, 37, flit width in bits
ADDR_WIDTH, 3, log2 of per-VC depth; DEPTH = 1<<ADDR_WIDTH entries per VC
NUM_VC, 4, number of virtual channels (>=2)
VC_W, $clog2(NUM_VC), width of the VC index
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset; synchronous, active-low
wr_en  in  1  write request
wr_vc  in  VC_W  target VC for the write
wr_data  in  DATA_WIDTH  flit to write
rd_en  in  1  read (pop) request
rd_vc  in  VC_W  VC to read from
rd_data  out  DATA_WIDTH  popped flit
rd_valid  out  1  rd_data holds a valid popped flit
empty  out  NUM_VC  per-VC empty flag
full  out  NUM_VC  per-VC full flag (count == DEPTH)
almost_full  out  NUM_VC  per-VC count >= AF_THRESH
count  out  NUM_VC*(ADDR_WIDTH+1)  packed per-VC occupancy; VC k occupies bits [k*(ADDR_WIDTH+1) +: ADDR_WIDTH+1]
overflow_err  out  1  sticky: a write to a full VC was dropped
underflow_err  out  1  sticky: a read from an empty VC was dropped

Behaviour:
- Reset is sampled on the clk edge with rst_n==0. It takes priority over all requests.
- Reset values:
  - all pointers and counts are 0, so empty is all-1s and full and almost_full are all-0s.
  - rd_data = 0, rd_valid = 0, overflow_err = 0, underflow_err = 0.
  - Memory contents are not cleared.
- Reset mid-operation discards all stored flits. Any request in the reset cycle is ignored.
- All flags are decoded combinationally from the registered counts. Full is true at DEPTH entries, so all DEPTH slots are usable.
- Write acceptance: wr_en && (!full[wr_vc] || (rd_en && rd_vc==wr_vc)). An accepted write stores wr_data at the VC's write pointer, and the pointer increments mod DEPTH.
- Write to a full VC without a same-VC read: the write is dropped, memory and pointers are unchanged, and overflow_err is set.
- Read acceptance: rd_en && !empty[rd_vc]. An accepted read registers the head flit into rd_data and increments the read pointer mod DEPTH.
- Read latency: rd_data and rd_valid are presented on the cycle after rd_en (1 cycle).
- rd_valid pulses for exactly one cycle per accepted read. rd_data holds its last value when no read is accepted.
- Read from an empty VC: no pop, rd_valid=0 next cycle, and underflow_err is set. This holds even if the same VC is written in the same cycle; the write is still accepted.
- Count update per VC:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - unchanged when both an accepted read and an accepted write hit the same VC.
  - Count never exceeds DEPTH and never goes below 0.
- Writes and reads to different VCs in the same cycle are fully independent.
- Out-of-range VC index (>= NUM_VC when NUM_VC is not a power of two): the request is ignored and the matching error flag is set.
- Sticky errors clear only on reset.

Optional Feature:
VC_FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - rd_data combinationally shows the head flit of rd_vc.
  - rd_valid = !empty[rd_vc], combinationally.
  - rd_en acknowledges and pops that flit in the same cycle, so read latency is 0.
  - The pass-through-on-full rule is unchanged.
- Undefined: registered 1-cycle read as described under Behaviour.

Decomposition:
- Package vc_fifo_pkg holds:
  - the DATA_WIDTH default
  - typedef flit_t (logic [DATA_WIDTH-1:0])
  - the vc_id_t typedef
  - a function computing the packed count slice offset
- Sub-module vc_fifo_chan: one single-VC storage unit containing pointers, count, memory, and the per-channel full/empty/almost_full flags. It is instantiated NUM_VC times via generate.
- The top level holds VC decode, the read mux, the output register and the error flags.

Test Plan:
- Reset, then write 8 flits 0x01..0x08 to VC2 -> full[2]=1 and count[2]=8; other VCs stay empty. Read 8 from VC2 -> data 0x01..0x08 in order, each one cycle after rd_en.
- 9th write to full VC2 -> dropped, overflow_err=1, count[2] stays 8. A subsequent read returns 0x01 (not the dropped flit).
- VC1 full, same-cycle write 0xAA plus read on VC1 -> read returns the oldest flit, 0xAA is accepted, count[1] stays 8, no overflow.
- Read VC0 while empty with same-cycle write 0x55 to VC0 -> rd_valid=0, underflow_err=1, count[0]=1. A next-cycle read returns 0x55.
- Interleave writes to VC0 and VC3 with reads from VC3 across pointer wrap (20 flits) -> per-VC order preserved, almost_full asserts at count 6.
- Assert rst_n=0 while VC0 holds 5 flits -> next cycle empty all-1s, count 0, errors cleared, rd_valid=0.
